// File: rtl/microtile_bist.sv
// Built-in self-test driver for a combinational tile: LFSR stimulus, MISR response compaction.
// Optional two-cycle apply/absorb vectors with `define MICROTILE_BIST_SETTLE_EN.
module microtile_bist #(
    parameter int          N_VECTORS = 255,
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter logic [15:0] GOLDEN    = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    output logic [7:0]  tile_ui_in,
    input  logic [7:0]  tile_uo_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DONE   = 2'd2
`ifdef MICROTILE_BIST_SETTLE_EN
        , S_SETTLE = 2'd3
`endif
    } state_t;

    localparam logic [7:0] LAST = 8'(N_VECTORS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_lfsr;
    logic [7:0]  w_lfsr_nxt;
    logic [7:0]  r_count;
    logic [7:0]  w_count_nxt;
    logic [15:0] r_misr;
    logic [15:0] w_misr_nxt;
    logic        w_absorb;
    logic        w_lfsr_fb;
    logic        w_misr_fb;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_misr_fb = r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10];

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_misr_nxt  = r_misr;
        w_count_nxt = r_count;
        w_absorb    = 1'b0;

        if (ena) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_RUN;
                        w_lfsr_nxt  = SEED;
                        w_misr_nxt  = 16'h0000;
                        w_count_nxt = 8'h00;
                    end
                end
`ifdef MICROTILE_BIST_SETTLE_EN
                S_RUN:    w_state_nxt = S_SETTLE;
                S_SETTLE: w_absorb    = 1'b1;
`else
                S_RUN:    w_absorb    = 1'b1;
`endif
                default:  w_state_nxt = S_IDLE;
            endcase
        end

        // The tile response is sampled while the current LFSR byte is still on its inputs.
        if (w_absorb) begin
            w_misr_nxt  = {r_misr[14:0], w_misr_fb} ^ {8'h00, tile_uo_out};
            w_lfsr_nxt  = {r_lfsr[6:0], w_lfsr_fb};
            w_count_nxt = r_count + 8'd1;
            w_state_nxt = (r_count == LAST) ? S_DONE : S_RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_lfsr  <= 8'h00;
            r_misr  <= 16'h0000;
            r_count <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_misr  <= w_misr_nxt;
            r_count <= w_count_nxt;
        end
    end

`ifdef MICROTILE_BIST_SETTLE_EN
    assign busy = (r_state == S_RUN) || (r_state == S_SETTLE);
`else
    assign busy = (r_state == S_RUN);
`endif
    assign done       = (r_state == S_DONE);
    assign pass       = done && (r_misr == GOLDEN);
    assign tile_ui_in = busy ? r_lfsr : 8'h00;
    assign signature  = r_misr;

endmodule

// File: tb/tb_microtile_bist.sv
// Directed self-checking bench for microtile_bist: three instances (1, 2 and 255 vectors).
module tb_microtile_bist;

`ifdef MICROTILE_BIST_SETTLE_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ena;
    logic start1, start2, start3, stuck3;
    logic [7:0] ui1, ui2, ui3, uo1, uo2, uo3;
    logic busy1, busy2, busy3, done1, done2, done3, pass1, pass2, pass3;
    logic [15:0] sig1, sig2, sig3;

    assign uo1 = ui1;
    assign uo2 = ui2;
    assign uo3 = stuck3 ? 8'h00 : ui3;

    microtile_bist #(.N_VECTORS(1), .SEED(8'hA5), .GOLDEN(16'h0100)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start1), .tile_ui_in(ui1),
        .tile_uo_out(uo1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

    microtile_bist #(.N_VECTORS(2), .SEED(8'hA5), .GOLDEN(16'h0100)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2), .tile_ui_in(ui2),
        .tile_uo_out(uo2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));

    microtile_bist #(.N_VECTORS(255), .SEED(8'hA5), .GOLDEN(16'h0100)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start3), .tile_ui_in(ui3),
        .tile_uo_out(uo3), .busy(busy3), .done(done3), .pass(pass3), .signature(sig3));

    int checks   = 0;
    int failures = 0;

    logic [7:0]  lfsr_exp [0:254];
    logic [15:0] exp_sig;
    logic [7:0]  m_lfsr;
    logic [15:0] m_misr;

    int n, busy_cyc, seq_err;
    logic [7:0] ui_a, ui_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs the 255-vector instance from a start pulse until busy drops, verifying the
    // stimulus byte on every busy cycle; optional 5-cycle ena pause and stray start pulses.
    task automatic run3(input int pause_at, input bit pulses, output int bc, output int serr);
        int act;
        bc   = 0;
        serr = 0;
        act  = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("start_clears_done", {31'd0, done3}, 32'd0);
        while (busy3 && bc < 2000) begin
            if (act / STEP > 254) serr++;
            else if (ui3 !== lfsr_exp[act / STEP]) serr++;
            start3 = (pulses && (act % 7 == 3));
            if (act == pause_at) begin
                ena = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    ui_a = ui3;
                    m_misr = sig3;
                    tick();
                    bc++;
                    if (ui3 !== ui_a || sig3 !== m_misr || busy3 !== 1'b1) serr++;
                end
                ena = 1'b1;
            end
            tick();
            bc++;
            act++;
        end
        start3 = 1'b0;
    endtask

    initial begin
        m_lfsr = 8'hA5;
        m_misr = 16'h0000;
        for (int i = 0; i < 255; i++) begin
            lfsr_exp[i] = m_lfsr;
            m_misr = {m_misr[14:0], m_misr[15] ^ m_misr[13] ^ m_misr[12] ^ m_misr[10]} ^ {8'h00, m_lfsr};
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
        exp_sig = m_misr;

        rst_n = 1'b0; ena = 1'b1; stuck3 = 1'b0;
        start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        tick();
        tick();
        check("rst_busy",   {31'd0, busy3}, 32'd0);
        check("rst_done",   {31'd0, done3}, 32'd0);
        check("rst_pass",   {31'd0, pass3}, 32'd0);
        check("rst_ui",     {24'd0, ui3},   32'd0);
        check("rst_sig",    {16'd0, sig3},  32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", {30'd0, busy3, done3}, 32'd0);

        // Single vector, loopback: one A5 absorb gives 0x00A5.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        ui_a = ui1;
        while (busy1 && n < 20) begin n++; tick(); end
        check("n1_busy_len", n, STEP);
        check("n1_ui",       {24'd0, ui_a}, 32'h0000_00A5);
        check("n1_sig",      {16'd0, sig1}, 32'h0000_00A5);
        check("n1_done",     {31'd0, done1}, 32'd1);
        check("n1_pass",     {31'd0, pass1}, 32'd0);

        // Two vectors: A5 then 4A, 0x00A5 -> 0x014A ^ 0x004A = 0x0100.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        ui_a = ui2;
        ui_b = 8'h00;
        while (busy2 && n < 20) begin
            if (n == STEP) ui_b = ui2;
            n++;
            tick();
        end
        check("n2_busy_len", n, 2 * STEP);
        check("n2_ui0",      {24'd0, ui_a}, 32'h0000_00A5);
        check("n2_ui1",      {24'd0, ui_b}, 32'h0000_004A);
        check("n2_sig",      {16'd0, sig2}, 32'h0000_0100);
        check("n2_pass",     {30'd0, done2, pass2}, 32'd3);

        // Stuck-at-zero tile over 255 vectors.
        stuck3 = 1'b1;
        run3(-1, 1'b0, busy_cyc, seq_err);
        check("stuck_busy_len", busy_cyc, 255 * STEP);
        check("stuck_seq",      seq_err, 0);
        check("stuck_sig",      {16'd0, sig3}, 32'd0);
        check("stuck_done_pass", {30'd0, done3, pass3}, 32'd2);
        stuck3 = 1'b0;

        // ena low blocks a start request in DONE.
        ena = 1'b0;
        start3 = 1'b1;
        tick();
        tick();
        start3 = 1'b0;
        ena = 1'b1;
        check("ena0_start_ignored", {30'd0, busy3, done3}, 32'd1);
        tick();
        check("ena0_still_done", {30'd0, busy3, done3}, 32'd1);

        // Fault-free loopback, then rerun from DONE.
        run3(-1, 1'b0, busy_cyc, seq_err);
        check("loop_busy_len", busy_cyc, 255 * STEP);
        check("loop_seq",      seq_err, 0);
        check("loop_sig",      {16'd0, sig3}, {16'd0, exp_sig});
        check("loop_pass",     {30'd0, done3, pass3}, {30'd0, 1'b1, exp_sig == 16'h0100});
        run3(-1, 1'b0, busy_cyc, seq_err);
        check("rerun_sig",     {16'd0, sig3}, {16'd0, exp_sig});

        // Paused for 5 cycles with stray start pulses while running.
        run3(20, 1'b1, busy_cyc, seq_err);
        check("pause_busy_len", busy_cyc, 255 * STEP + 5);
        check("pause_seq",      seq_err, 0);
        check("pause_sig",      {16'd0, sig3}, {16'd0, exp_sig});

        // Reset at vector 10 aborts asynchronously.
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (10 * STEP) tick();
        check("pre_abort_ui", {24'd0, ui3}, {24'd0, lfsr_exp[10]});
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy3}, 32'd0);
        check("abort_ui",   {24'd0, ui3},   32'd0);
        check("abort_sig",  {16'd0, sig3},  32'd0);
        check("abort_done", {31'd0, done3}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("abort_needs_start", {30'd0, busy3, done3}, 32'd0);
        run3(-1, 1'b0, busy_cyc, seq_err);
        check("after_abort_sig", {16'd0, sig3}, {16'd0, exp_sig});
        check("after_abort_seq", seq_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
